// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - decode stage with register file, WB bypass, load-use stall, flush, halt and ID/EX register
module id_stage_pipe #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  parameter bit BYPASS = 1'b1,
  localparam int RA_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       instr,
  input  logic [DATA_W-1:0] pc,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [RA_W-1:0]   ex_rd,
  input  logic              wb_we,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              halt,
  output logic              id_valid,
  output logic [DATA_W-1:0] pc_q,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] imm,
  output logic [RA_W-1:0]   rd,
  output logic [6:0]        ex_ctrl,
  output logic [1:0]        mem_ctrl,
  output logic [1:0]        wb_ctrl
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  logic              halt_q, halt_d, id_valid_q, id_valid_d;
  logic [DATA_W-1:0] pc_d, rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic [RA_W-1:0]   rd_q, rd_d;
  logic [6:0]        ex_ctrl_q, ex_ctrl_d;
  logic [1:0]        mem_ctrl_q, mem_ctrl_d, wb_ctrl_q, wb_ctrl_d;

  logic [3:0]        op;
  logic [RA_W-1:0]   fa, fb, fc, rs_a, rt_a;
  logic              rs_used, rt_used, reg_write, alu_src, reg_dst, pcs;
  logic              mem_read, mem_write, is_hlt, hz, issue;
  logic [DATA_W-1:0] imm_dec, rs_val, rt_val;

  assign op = instr[15:12];
  assign fa = instr[8 +: RA_W];
  assign fb = instr[4 +: RA_W];
  assign fc = instr[0 +: RA_W];

  always_comb begin
    rs_used   = 1'b0;
    rt_used   = 1'b0;
    reg_write = 1'b0;
    alu_src   = 1'b0;
    reg_dst   = 1'b0;
    pcs       = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    is_hlt    = 1'b0;
    rs_a      = fb;
    rt_a      = fc;
    imm_dec   = '0;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3: begin
        rs_used   = 1'b1;
        rt_used   = 1'b1;
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      4'h4, 4'h5, 4'h6: begin
        rs_used   = 1'b1;
        reg_write = 1'b1;
        alu_src   = 1'b1;
        imm_dec   = {{(DATA_W-4){1'b0}}, instr[3:0]};
      end
      4'h8: begin
        rs_used   = 1'b1;
        reg_write = 1'b1;
        alu_src   = 1'b1;
        mem_read  = 1'b1;
        rt_a      = fa;
        imm_dec   = {{(DATA_W-5){instr[3]}}, instr[3:0], 1'b0};
      end
      4'h9: begin
        rs_used   = 1'b1;
        rt_used   = 1'b1;
        alu_src   = 1'b1;
        mem_write = 1'b1;
        rt_a      = fa;
        imm_dec   = {{(DATA_W-5){instr[3]}}, instr[3:0], 1'b0};
      end
      4'hA, 4'hB: begin
        rs_used   = 1'b1;
        reg_write = 1'b1;
        alu_src   = 1'b1;
        rs_a      = fa;
        imm_dec   = {{(DATA_W-8){1'b0}}, instr[7:0]};
      end
      4'hD: rs_used = 1'b1;
      4'hE: begin
        reg_write = 1'b1;
        pcs       = 1'b1;
      end
      4'hF: is_hlt = 1'b1;
      default: ;
    endcase
  end

  // R0 is hard zero; a same-cycle WB write is forwarded only when BYPASS is set
  always_comb begin
    rs_val = regs_q[rs_a];
    rt_val = regs_q[rt_a];
    if (BYPASS && wb_we && (wb_rd == rs_a)) rs_val = wb_data;
    if (BYPASS && wb_we && (wb_rd == rt_a)) rt_val = wb_data;
    if (rs_a == '0) rs_val = '0;
    if (rt_a == '0) rt_val = '0;
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_we && (wb_rd != '0)) regs_d[wb_rd] = wb_data;
  end

  assign hz = if_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
              ((rs_used & (rs_a == ex_rd)) | (rt_used & (rt_a == ex_rd)));
  assign stall = hz & ~flush & ~halt_q;
  assign issue = if_valid & ~flush & ~halt_q & ~hz;

  always_comb begin
    halt_d     = halt_q;
    id_valid_d = 1'b0;
    pc_d       = pc_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;
    rd_d       = rd_q;
    ex_ctrl_d  = '0;
    mem_ctrl_d = '0;
    wb_ctrl_d  = '0;
    if (issue) begin
      id_valid_d = 1'b1;
      pc_d       = pc;
      rs_data_d  = rs_val;
      rt_data_d  = rt_val;
      imm_d      = imm_dec;
      rd_d       = fa;
      if (is_hlt) begin
        halt_d = 1'b1;
      end else begin
        ex_ctrl_d  = {pcs, alu_src, reg_dst, op};
        mem_ctrl_d = {mem_read, mem_write};
        wb_ctrl_d  = {mem_read, reg_write};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      halt_q     <= 1'b0;
      id_valid_q <= 1'b0;
      pc_q       <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
      ex_ctrl_q  <= '0;
      mem_ctrl_q <= '0;
      wb_ctrl_q  <= '0;
    end else begin
      regs_q     <= regs_d;
      halt_q     <= halt_d;
      id_valid_q <= id_valid_d;
      pc_q       <= pc_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      rd_q       <= rd_d;
      ex_ctrl_q  <= ex_ctrl_d;
      mem_ctrl_q <= mem_ctrl_d;
      wb_ctrl_q  <= wb_ctrl_d;
    end
  end

  assign halt     = halt_q;
  assign id_valid = id_valid_q;
  assign rs_data  = rs_data_q;
  assign rt_data  = rt_data_q;
  assign imm      = imm_q;
  assign rd       = rd_q;
  assign ex_ctrl  = ex_ctrl_q;
  assign mem_ctrl = mem_ctrl_q;
  assign wb_ctrl  = wb_ctrl_q;

endmodule
